// File: rtl/fetch_queue.sv
// fetch_queue: fetches instruction cache lines, extracts words one per cycle
// into an issue queue, and stops fetching on a halt word.
// The optional macro FETCH_JUMP_EN lets the fetcher follow opcode-1110 jumps
// without enqueueing them. Without the macro, those words are enqueued like
// any other word.
// The opcode is taken from the top four bits of each word. The jump offset is
// inst[27:0]. These fields assume WORD_SIZE >= 32 and, with FETCH_JUMP_EN,
// PC_WIDTH > 28.
module fetch_queue #(
    parameter int WORD_SIZE  = 32,
    parameter int LINE_WORDS = 32,
    parameter int QDEPTH     = 8,
    parameter int PC_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            ic_req,
    output logic [PC_WIDTH-1:0]             ic_addr,
    input  logic                            ic_hit,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] ic_line,
    output logic                            iss_valid,
    output logic [WORD_SIZE-1:0]            iss_inst,
    output logic [PC_WIDTH-1:0]             iss_pc,
    input  logic                            iss_ready,
    input  logic                            redir_valid,
    input  logic [PC_WIDTH-1:0]             redir_pc,
    output logic                            halted
);

    localparam int OFFW = $clog2(LINE_WORDS);
    localparam int QW   = $clog2(QDEPTH);

    typedef enum logic [1:0] {FETCH, EXTRACT, HALT} state_t;

    state_t                          state;
    logic [PC_WIDTH-1:0]             pc;
    logic [OFFW-1:0]                 offset;
    logic [LINE_WORDS*WORD_SIZE-1:0] line;

    logic [WORD_SIZE-1:0] q_inst [QDEPTH];
    logic [PC_WIDTH-1:0]  q_pc   [QDEPTH];
    logic [QW-1:0]        head;
    logic [QW-1:0]        tail;
    logic [QW:0]          count;

    logic [WORD_SIZE-1:0] words [LINE_WORDS];
    logic [WORD_SIZE-1:0] cur_word;
    logic [PC_WIDTH-1:0]  cur_pc;
    logic [PC_WIDTH-1:0]  line_base;
    logic [PC_WIDTH-1:0]  next_line;
    logic [3:0]           opcode;
    logic                 in_extract;
    logic                 is_zero;
    logic                 is_halt;
    logic                 take_jump;
    logic                 full;
    logic                 needs_enq;
    logic                 stall;
    logic                 enq;
    logic                 deq;

    // Slice the latched line into words. Word 0 sits in the most-significant bits.
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_words
        assign words[i] = line[(LINE_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
    end

    assign cur_word   = words[offset];
    assign cur_pc     = {pc[PC_WIDTH-1:OFFW], offset};
    assign line_base  = {pc[PC_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign next_line  = line_base + PC_WIDTH'(LINE_WORDS);
    assign opcode     = cur_word[WORD_SIZE-1 -: 4];
    assign in_extract = (state == EXTRACT);
    assign is_zero    = (cur_word == '0);
    assign is_halt    = (opcode == 4'b0001);
    assign full       = (count == (QW+1)'(QDEPTH));

`ifdef FETCH_JUMP_EN
    logic [PC_WIDTH-1:0] jump_target;
    assign take_jump   = in_extract && (opcode == 4'b1110);
    assign jump_target = cur_pc + {{(PC_WIDTH-28){cur_word[27]}}, cur_word[27:0]};
`else
    assign take_jump   = 1'b0;
`endif

    // A non-zero, non-jump word needs a queue slot. Extraction stalls while the
    // queue is full, even when the head pops this cycle. A redirect cancels any
    // enqueue or pop in the same cycle.
    assign needs_enq = in_extract && !is_zero && !take_jump;
    assign stall     = needs_enq && full;
    assign enq       = needs_enq && !full && !redir_valid;
    assign deq       = iss_valid && iss_ready && !redir_valid;

    assign iss_valid = (count != '0);
    assign iss_inst  = q_inst[head];
    assign iss_pc    = q_pc[head];

    // Circular issue queue. Reset and redirect flush it, and a simultaneous push
    // and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst || redir_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                q_inst[tail] <= cur_word;
                q_pc[tail]   <= cur_pc;
                tail         <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Fetch control FSM with registered request, address and halt outputs.
    // A redirect overrides every state, including HALT and a same-cycle hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= '0;
            offset  <= '0;
            line    <= '0;
            ic_req  <= 1'b0;
            ic_addr <= '0;
            halted  <= 1'b0;
        end else if (redir_valid) begin
            state   <= FETCH;
            pc      <= redir_pc;
            ic_req  <= 1'b1;
            ic_addr <= {redir_pc[PC_WIDTH-1:OFFW], {OFFW{1'b0}}};
            halted  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ic_req  <= 1'b1;
                    ic_addr <= line_base;
                    if (ic_req && ic_hit) begin
                        line   <= ic_line;
                        offset <= pc[OFFW-1:0];
                        ic_req <= 1'b0;
                        state  <= EXTRACT;
                    end
                end
                EXTRACT: begin
                    if (!stall) begin
                        if (take_jump) begin
`ifdef FETCH_JUMP_EN
                            pc      <= jump_target;
                            ic_addr <= {jump_target[PC_WIDTH-1:OFFW], {OFFW{1'b0}}};
`endif
                            ic_req  <= 1'b1;
                            state   <= FETCH;
                        end else if (!is_zero && is_halt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else if (offset == OFFW'(LINE_WORDS-1)) begin
                            pc      <= next_line;
                            ic_addr <= next_line;
                            ic_req  <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            offset <= offset + 1'b1;
                        end
                    end
                end
                HALT: begin
                    ic_req <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with the default parameters.
// A zero-latency instruction cache model serves lines from a small memory.
// Every issued head is logged, and each scenario compares the log and the
// outputs against hand-computed values.
module tb_fetch_queue;

    logic          clk;
    logic          rst;
    logic          ic_req;
    logic [31:0]   ic_addr;
    logic          ic_hit;
    logic [1023:0] ic_line;
    logic          iss_valid;
    logic [31:0]   iss_inst;
    logic [31:0]   iss_pc;
    logic          iss_ready;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          halted;

    logic [31:0] mem [256];
    logic [31:0] issuedPc[$];
    logic [31:0] issuedInst[$];
    int          assertCount;
    int          failCount;
    logic        sawReq;
    logic        stayedHalted;

    fetch_queue dut (
        .clk(clk),
        .rst(rst),
        .ic_req(ic_req),
        .ic_addr(ic_addr),
        .ic_hit(ic_hit),
        .ic_line(ic_line),
        .iss_valid(iss_valid),
        .iss_inst(iss_inst),
        .iss_pc(iss_pc),
        .iss_ready(iss_ready),
        .redir_valid(redir_valid),
        .redir_pc(redir_pc),
        .halted(halted)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The cache always hits. It returns the 32 words at the requested line base,
    // with word 0 in the most-significant bits.
    assign ic_hit = ic_req;
    always_comb begin
        ic_line = '0;
        for (int i = 0; i < 32; i++) begin
            ic_line[(31-i)*32 +: 32] = mem[8'(ic_addr[7:0] + 8'(i))];
        end
    end

    // Log every head that pops. Sampling on the falling edge keeps it away from
    // the active edge.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            issuedPc.push_back(iss_pc);
            issuedInst.push_back(iss_inst);
        end
    end

    function automatic logic [31:0] pcAt(int i);
        if (i < issuedPc.size()) return issuedPc[i];
        return 'x;
    endfunction

    function automatic logic [31:0] instAt(int i);
        if (i < issuedInst.size()) return issuedInst[i];
        return 'x;
    endfunction

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Hold reset for two edges, check the reset outputs, then release reset.
    task automatic resetDut();
        rst = 1'b1;
        redir_valid = 1'b0;
        applyStimulus(2);
        issuedPc.delete();
        issuedInst.delete();
        checkOutput("rst_outputs", {61'h0, ic_req, iss_valid, halted}, 64'h0);
        rst = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        iss_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        clearMem();

        // Sequential fetch: eight non-zero words, then zeros, then the next line.
        for (int i = 0; i < 8; i++) mem[i] = 32'h0200_0000 + 32'(i + 1);
        iss_ready = 1'b1;
        resetDut();
        checkOutput("rst_no_req_while_held", {63'h0, ic_req}, 64'h0);
        applyStimulus(1);
        checkOutput("first_req", {31'h0, ic_req, ic_addr}, {31'h0, 1'b1, 32'd0});
        for (int c = 0; c < 100 && !(ic_req && ic_addr == 32'd32); c++) applyStimulus(1);
        checkOutput("seq_next_line", {31'h0, ic_req, ic_addr}, {31'h0, 1'b1, 32'd32});
        checkOutput("seq_count", 64'(issuedPc.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("seq_pc%0d", i), {32'h0, pcAt(i)}, 64'(i));
        end
        checkOutput("seq_inst7", {32'h0, instAt(7)}, 64'h0200_0008);

        // Backpressure: ten words with the issue side blocked.
        clearMem();
        for (int i = 0; i < 10; i++) mem[i] = 32'h3000_0100 + 32'(i);
        iss_ready = 1'b0;
        resetDut();
        applyStimulus(20);
        checkOutput("bp_stalled", {30'h0, iss_valid, ic_req, iss_pc},
                    {30'h0, 1'b1, 1'b0, 32'd0});
        checkOutput("bp_none_issued", 64'(issuedPc.size()), 64'd0);
        iss_ready = 1'b1;
        applyStimulus(30);
        checkOutput("bp_count", 64'(issuedPc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_pc%0d", i), {32'h0, pcAt(i)}, 64'(i));
            checkOutput($sformatf("bp_inst%0d", i), {32'h0, instAt(i)},
                        64'(32'h3000_0100 + 32'(i)));
        end

        // Redirect to pc 70 while five entries are queued.
        clearMem();
        for (int i = 0; i < 10; i++) mem[i] = 32'h2000_0000 + 32'(i);
        for (int i = 64; i < 70; i++) mem[i] = 32'h4000_0AAA;
        mem[70] = 32'h5000_0070;
        mem[71] = 32'h5000_0071;
        iss_ready = 1'b0;
        resetDut();
        applyStimulus(7);
        checkOutput("redir_before", {63'h0, iss_valid}, 64'h1);
        redir_valid = 1'b1;
        redir_pc    = 32'd70;
        applyStimulus(1);
        redir_valid = 1'b0;
        checkOutput("redir_flush", {62'h0, iss_valid, ic_req}, {62'h0, 1'b0, 1'b1});
        checkOutput("redir_addr", {32'h0, ic_addr}, 64'd64);
        iss_ready = 1'b1;
        applyStimulus(10);
        checkOutput("redir_first_pc", {32'h0, pcAt(0)}, 64'd70);
        checkOutput("redir_first_inst", {32'h0, instAt(0)}, 64'h5000_0070);
        checkOutput("redir_second_pc", {32'h0, pcAt(1)}, 64'd71);

        // Halt word at pc 3, followed by a redirect out of HALT.
        clearMem();
        mem[0] = 32'h2000_0001;
        mem[1] = 32'h2000_0002;
        mem[2] = 32'h2000_0003;
        mem[3] = 32'h1000_0000;
        mem[4] = 32'h2000_0005;
        iss_ready = 1'b1;
        resetDut();
        applyStimulus(10);
        checkOutput("halt_flag", {63'h0, halted}, 64'h1);
        checkOutput("halt_count", 64'(issuedPc.size()), 64'd4);
        checkOutput("halt_last_pc", {32'h0, pcAt(3)}, 64'd3);
        checkOutput("halt_last_inst", {32'h0, instAt(3)}, 64'h1000_0000);
        sawReq = 1'b0;
        stayedHalted = 1'b1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1);
            if (ic_req) sawReq = 1'b1;
            if (!halted) stayedHalted = 1'b0;
        end
        checkOutput("halt_no_req", {62'h0, sawReq, stayedHalted}, {62'h0, 1'b0, 1'b1});
        redir_valid = 1'b1;
        redir_pc    = 32'd4;
        applyStimulus(1);
        redir_valid = 1'b0;
        checkOutput("halt_exit", {62'h0, halted, ic_req}, {62'h0, 1'b0, 1'b1});

        // Reset in EXTRACT with three entries queued.
        clearMem();
        for (int i = 0; i < 10; i++) mem[i] = 32'h2000_0010 + 32'(i);
        iss_ready = 1'b0;
        resetDut();
        applyStimulus(5);
        checkOutput("midrst_before", {63'h0, iss_valid}, 64'h1);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midrst_flush", {62'h0, iss_valid, ic_req}, 64'h0);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("midrst_restart", {31'h0, ic_req, ic_addr}, {31'h0, 1'b1, 32'd0});

        // Opcode 1110 at pc 5 with an offset of -5.
        clearMem();
        for (int i = 0; i < 5; i++) mem[i] = 32'h2000_0020 + 32'(i);
        mem[5] = 32'hEFFF_FFFB;
        mem[6] = 32'h2000_0026;
        iss_ready = 1'b1;
        resetDut();
        applyStimulus(30);
`ifdef FETCH_JUMP_EN
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("jump_pc%0d", i), {32'h0, pcAt(i)}, 64'(i));
        end
        checkOutput("jump_target_pc", {32'h0, pcAt(5)}, 64'd0);
        checkOutput("jump_target_inst", {32'h0, instAt(5)}, 64'h2000_0020);
`else
        checkOutput("jumpword_pc", {32'h0, pcAt(5)}, 64'd5);
        checkOutput("jumpword_inst", {32'h0, instAt(5)}, 64'hEFFF_FFFB);
        checkOutput("jumpword_next_pc", {32'h0, pcAt(6)}, 64'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction word width in bits.
REQ-002 Parameter LINE_WORDS, default 32, words per cache line; power of two, at least 2.
REQ-003 Parameter QDEPTH, default 8, instruction queue entries; power of two, at least 2.
REQ-004 Parameter PC_WIDTH, default 32, PC width in bits; the PC counts words.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ic_req  output  1  line request to instcache.
REQ-008 ic_addr  output  PC_WIDTH  line base address (PC with low log2(LINE_WORDS) bits zero).
REQ-009 ic_hit  input  1  ic_line valid for ic_addr.
REQ-010 ic_line  input  LINE_WORDS*WORD_SIZE  line data; word 0 occupies the most-significant WORD_SIZE bits.
REQ-011 iss_valid  output  1  queue head valid.
REQ-012 iss_inst  output  WORD_SIZE  queue head instruction.
REQ-013 iss_pc  output  PC_WIDTH  queue head PC.
REQ-014 iss_ready  input  1  RS accepts head this cycle.
REQ-015 redir_valid  input  1  execute-stage redirect, e.g. taken bgt.
REQ-016 redir_pc  input  PC_WIDTH  redirect target.
REQ-017 halted  output  1  halt word fetched; fetch stopped.

Function
REQ-018 FSM states are FETCH, EXTRACT and HALT.
REQ-019 FETCH: ic_req=1, ic_addr=line base of pc; on ic_hit, latch ic_line and move to EXTRACT at offset pc mod LINE_WORDS next cycle.
REQ-020 EXTRACT handles one word per cycle.
- Word 0: skip, no enqueue, advance offset.
- Word with opcode [31:28]=0001: enqueue, go to HALT.
- Other words: enqueue with its PC, advance offset.
REQ-021 EXTRACT stalls with no state change while queue count equals QDEPTH; enqueue is allowed only when count<QDEPTH, even if a dequeue happens the same cycle.
REQ-022 After the last offset in the line, pc becomes line base plus LINE_WORDS and the FSM goes to FETCH; the PC wraps modulo 2^PC_WIDTH.
REQ-023 iss_valid is 1 when count is not 0; iss_inst and iss_pc show the head entry; the head pops when iss_valid and iss_ready are both 1.
REQ-024 Enqueue and dequeue in the same cycle leave count unchanged.
REQ-025 On redir_valid, in any state:
- flush the queue (count=0), discard the latched line, set pc=redir_pc, go to FETCH next cycle;
- a concurrent pop or enqueue has no effect;
- redirect takes priority over HALT and over a same-cycle ic_hit.
REQ-026 HALT: ic_req=0, halted=1; the queue keeps draining; the state is left only on redir_valid or rst.

Reset
REQ-027 While rst=1: pc=0, state=FETCH, count=0, head and tail pointers=0, halted=0, iss_valid=0, ic_req=0.
REQ-028 ic_req is first asserted in the cycle after rst deasserts.
REQ-029 Reset mid-operation discards any outstanding request, the latched line and all queue contents.

Configuration
REQ-030 Macro FETCH_JUMP_EN, when defined: a word with opcode 1110 is not enqueued; pc = word PC + sign-extended inst[27:0]; the FSM goes to FETCH next cycle. Earlier entries remain queued.
REQ-031 Without FETCH_JUMP_EN, opcode 1110 is enqueued like any other word; fetch continues sequentially until redir_valid.

Verification
REQ-032 Sequential fetch: line 0 = words 1..8 nonzero then zeros, LINE_WORDS=32, iss_ready=1 -> iss_pc 0..7 issued in order; then ic_req with ic_addr=32.
REQ-033 Backpressure: iss_ready=0, 10 nonzero words -> count stops at 8 and EXTRACT stalls; iss_ready=1 -> all 10 issued in order, none lost or duplicated.
REQ-034 Redirect: redir_valid with redir_pc=70 while the queue holds 5 entries -> iss_valid=0 next cycle; then ic_addr=64, and the first issued iss_pc is 70.
REQ-035 Halt: word 3 = 0x10000000 -> words 0..3 issued; halted=1; ic_req stays 0 for 20 cycles.
REQ-036 With FETCH_JUMP_EN: jump word at pc 5 with offset -5 -> not issued; the next ic_addr is 0 and the next iss_pc after 4 is 0.
REQ-037 Reset mid-EXTRACT with 3 queued entries -> iss_valid=0 the next cycle; the fetch restarts at ic_addr=0.
